// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the mc_core RV-style integer core.
// Holds the opcode and funct encodings the core decodes, the ebreak
// instruction word, and the control FSM state enum. The HALT state exists
// only when MC_CORE_EBREAK_EN is defined.
package mc_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
`ifdef MC_CORE_EBREAK_EN
    , S_HALT = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: architectural register file for mc_core.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset (clears every entry)
//   raddr1/rdata1    - asynchronous read port 1
//   raddr2/rdata2    - asynchronous read port 2
//   we/waddr/wdata   - synchronous write port
// Entry 0 is hardwired to zero: writes to it are dropped and reads return 0.
module mc_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle integer core executing addi, add, sub, lui, auipc,
// jal and jalr. Every instruction walks FETCH -> EXEC -> WB, so it takes at
// least three cycles; everything else retires as illegal.
// Optional feature: define MC_CORE_EBREAK_EN to make ebreak halt the core
// (adds the halt output and the HALT state).
// Ports:
//   clk, rstn           - clock, asynchronous active-low reset
//   inst_valid, inst    - instruction word for the current pc
//   inst_ready          - high only in FETCH
//   pc                  - address of the instruction being fetched/executed
//   wb_valid            - one-cycle retire pulse (WB state)
//   result              - value written to rd (or link value); 0 when illegal
//   ill_inst            - one-cycle pulse with wb_valid for illegal instructions
//   halt                - (MC_CORE_EBREAK_EN only) core halted by ebreak
//   state               - current FSM state, for observation
// Handshake: an instruction is accepted on a rising edge where inst_valid
// and inst_ready are both high; inst and inst_valid are ignored otherwise.
module mc_core
  import mc_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic            inst_ready,
  output logic [XLEN-1:0] pc,
  output logic            wb_valid,
  output logic [XLEN-1:0] result,
  output logic            ill_inst,
`ifdef MC_CORE_EBREAK_EN
  output logic            halt,
`endif
  output state_t          state
);

  localparam int AW = $clog2(NREG);

  state_t          state_nxt;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] npc_q;
  logic            wen_q;
  logic            ill_q;

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_idx;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] jalr_sum;

  logic [XLEN-1:0] ex_res;
  logic [XLEN-1:0] ex_npc;
  logic            ex_wen;
  logic            ex_ill;
  logic            use_rs1;
  logic            use_rs2;
`ifdef MC_CORE_EBREAK_EN
  logic            ex_brk;
  logic            brk_q;
`endif

  assign opcode  = inst_q[6:0];
  assign rd_idx  = inst_q[11:7];
  assign funct3  = inst_q[14:12];
  assign rs1_idx = inst_q[19:15];
  assign rs2_idx = inst_q[24:20];
  assign funct7  = inst_q[31:25];

  assign imm_i    = XLEN'($signed(inst_q[31:20]));
  assign imm_u    = XLEN'($signed({inst_q[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
  assign pc4      = pc + XLEN'(4);
  assign jalr_sum = rs1_val + imm_i;

  mc_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk    (clk),
    .rstn   (rstn),
    .raddr1 (rs1_idx[AW-1:0]),
    .rdata1 (rs1_val),
    .raddr2 (rs2_idx[AW-1:0]),
    .rdata2 (rs2_val),
    .we     ((state == S_WB) && wen_q),
    .waddr  (rd_idx[AW-1:0]),
    .wdata  (result)
  );

  // Decode and execute the latched word; sampled into registers in EXEC.
  always_comb begin
    ex_res  = '0;
    ex_npc  = pc4;
    ex_wen  = 1'b0;
    ex_ill  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
`ifdef MC_CORE_EBREAK_EN
    ex_brk  = 1'b0;
`endif
    case (opcode)
      OP_IMM: begin
        use_rs1 = 1'b1;
        if (funct3 == F3_ADD) begin
          ex_res = rs1_val + imm_i;
          ex_wen = 1'b1;
        end else begin
          ex_ill = 1'b1;
        end
      end
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if ((funct3 == F3_ADD) && (funct7 == F7_ADD)) begin
          ex_res = rs1_val + rs2_val;
          ex_wen = 1'b1;
        end else if ((funct3 == F3_ADD) && (funct7 == F7_SUB)) begin
          ex_res = rs1_val - rs2_val;
          ex_wen = 1'b1;
        end else begin
          ex_ill = 1'b1;
        end
      end
      OP_LUI: begin
        ex_res = imm_u;
        ex_wen = 1'b1;
      end
      OP_AUIPC: begin
        ex_res = pc + imm_u;
        ex_wen = 1'b1;
      end
      OP_JAL: begin
        ex_res = pc4;
        ex_npc = pc + imm_j;
        ex_wen = 1'b1;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        if (funct3 == F3_ADD) begin
          ex_res = pc4;
          ex_npc = {jalr_sum[XLEN-1:1], 1'b0};
          ex_wen = 1'b1;
        end else begin
          ex_ill = 1'b1;
        end
      end
      default: ex_ill = 1'b1;
    endcase
`ifdef MC_CORE_EBREAK_EN
    // ebreak retires cleanly and leaves pc pointing at itself.
    if (inst_q == EBREAK_INST) begin
      ex_brk = 1'b1;
      ex_ill = 1'b0;
      ex_npc = pc;
    end
`endif
    // With a 16-entry file, any used register index above 15 is illegal.
    if ((NREG < 32) && !ex_ill &&
        (rd_idx[4] || (use_rs1 && rs1_idx[4]) || (use_rs2 && rs2_idx[4])))
      ex_ill = 1'b1;
    if (ex_ill) begin
      ex_res = '0;
      ex_wen = 1'b0;
      ex_npc = pc4;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (inst_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB: begin
        state_nxt = S_FETCH;
`ifdef MC_CORE_EBREAK_EN
        if (brk_q) state_nxt = S_HALT;
`endif
      end
`ifdef MC_CORE_EBREAK_EN
      S_HALT:  state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // FSM outputs
  always_comb begin
    inst_ready = (state == S_FETCH);
    wb_valid   = (state == S_WB);
    ill_inst   = (state == S_WB) && ill_q;
`ifdef MC_CORE_EBREAK_EN
    halt       = (state == S_HALT);
`endif
  end

  // Datapath registers: latch in FETCH, capture results in EXEC, commit pc in WB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_q <= '0;
      pc     <= RESET_PC[XLEN-1:0];
      result <= '0;
      npc_q  <= '0;
      wen_q  <= 1'b0;
      ill_q  <= 1'b0;
`ifdef MC_CORE_EBREAK_EN
      brk_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: if (inst_valid) inst_q <= inst;
        S_EXEC: begin
          result <= ex_res;
          npc_q  <= ex_npc;
          wen_q  <= ex_wen;
          ill_q  <= ex_ill;
`ifdef MC_CORE_EBREAK_EN
          brk_q  <= ex_brk;
`endif
        end
        S_WB:    pc <= npc_q;
        default: ;
      endcase
    end
  end

endmodule
